// File: rtl/link_obuf_pkg.sv
// Shared flit field defines plus the types and helpers used across the link output buffer.
// The optional packet checker is enabled with the LINK_OBUF_PCHK_EN macro.
`ifndef LINK_DEFINES_SV
`define LINK_DEFINES_SV
`define DATAW      31
`define DATAW_P1   32
`define VCHW       1
`define VCHW_P1    2
`define TYPE_MSB   31
`define TYPE_LSB   30
`define TYPE_NONE  2'b00
`define TYPE_HEAD  2'b01
`define TYPE_DATA  2'b10
`define TYPE_TAIL  2'b11
`endif

package link_obuf_pkg;

    typedef enum logic [1:0] {
        FT_NONE = `TYPE_NONE,
        FT_HEAD = `TYPE_HEAD,
        FT_DATA = `TYPE_DATA,
        FT_TAIL = `TYPE_TAIL
    } flit_type_e;

    typedef enum logic {
        CHK_IDLE = 1'b0,
        CHK_BODY = 1'b1
    } chk_state_e;

    localparam int FLIT_W  = `DATAW_P1;
    localparam int VCH_W   = `VCHW_P1;
    localparam int ENTRY_W = FLIT_W + VCH_W;

    function automatic flit_type_e flit_type(input logic [`DATAW_P1-1:0] d);
        return flit_type_e'(d[`TYPE_MSB:`TYPE_LSB]);
    endfunction

endpackage

// File: rtl/link_obuf_if.sv
// Handshake bundle between the mux (push side) and the link (pop side) of the output buffer.
interface link_obuf_if #(parameter int DEPTH = 4);

    logic [`DATAW_P1-1:0]   idata;
    logic                   ivalid;
    logic [`VCHW_P1-1:0]    ivch;
    logic                   iready;
    logic [`DATAW_P1-1:0]   odata;
    logic                   ovalid;
    logic [`VCHW_P1-1:0]    ovch;
    logic                   oready;
    logic [$clog2(DEPTH):0] occ;

    modport slave (
        input  idata, ivalid, ivch, oready,
        output iready, odata, ovalid, ovch, occ
    );

    modport master (
        output idata, ivalid, ivch, oready,
        input  iready, odata, ovalid, ovch, occ
    );

endinterface

// File: rtl/link_obuf_flit_fifo.sv
// Registered-storage FIFO holding {vc, flit} entries; head is read straight from storage.
module flit_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTRW  = $clog2(DEPTH),
    localparam int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wdata,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic [CNTW-1:0]  occ
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  occ_q, occ_d;
    logic             push, pop;

    assign full  = (occ_q == CNTW'(DEPTH));
    assign valid = (occ_q != '0);
    assign rdata = mem_q[rd_ptr_q];
    assign occ   = occ_q;

    // Full blocks pushes even when a pop happens this cycle; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        push     = push_req && !full;
        pop      = pop_req && valid;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + CNTW'(1);
            2'b01:   occ_d = occ_q - CNTW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/link_obuf.sv
// Link output buffer: FIFO between the VC mux and the link, with an optional push-side
// packet-framing checker compiled in by LINK_OBUF_PCHK_EN (adds the perr port).
module link_obuf
    import link_obuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    link_obuf_if.slave  bus
`ifdef LINK_OBUF_PCHK_EN
    ,
    output logic        perr
`endif
);

    logic               fifo_full;
    logic [ENTRY_W-1:0] head;

    flit_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wdata    ({bus.ivch, bus.idata}),
        .push_req (bus.ivalid),
        .pop_req  (bus.oready),
        .full     (fifo_full),
        .valid    (bus.ovalid),
        .rdata    (head),
        .occ      (bus.occ)
    );

    assign bus.iready           = !fifo_full;
    assign {bus.ovch, bus.odata} = head;

`ifdef LINK_OBUF_PCHK_EN
    chk_state_e       state_q, state_d;
    logic [VCH_W-1:0] vc_q, vc_d;
    logic             perr_q, perr_d;
    logic             push_acc;
    flit_type_e       in_type;

    // Observes accepted pushes only; it never back-pressures or drops anything.
    always_comb begin
        push_acc = bus.ivalid && bus.iready;
        in_type  = flit_type(bus.idata);
        state_d  = state_q;
        vc_d     = vc_q;
        perr_d   = perr_q;
        if (push_acc) begin
            case (state_q)
                CHK_IDLE: begin
                    if (in_type == FT_HEAD) begin
                        state_d = CHK_BODY;
                        vc_d    = bus.ivch;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                CHK_BODY: begin
                    case (in_type)
                        FT_DATA: begin
                            if (bus.ivch != vc_q) perr_d = 1'b1;
                        end
                        FT_TAIL: begin
                            state_d = CHK_IDLE;
                            if (bus.ivch != vc_q) perr_d = 1'b1;
                        end
                        FT_HEAD: begin
                            perr_d = 1'b1;
                            vc_d   = bus.ivch;
                        end
                        FT_NONE: begin
                            perr_d = 1'b1;
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CHK_IDLE;
            vc_q    <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vc_q    <= vc_d;
            perr_q  <= perr_d;
        end
    end

    assign perr = perr_q;
`endif

endmodule

// File: doc/link_obuf.md
LINK_OBUF -- requirements
Module: link_obuf

Interface
REQ-001 Parameter DEPTH, default 4, number of flit entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 idata  input  `DATAW_P1  flit from mux odata; top 2 bits carry `TYPE_* code.
REQ-005 ivalid  input  1  flit valid from mux ovalid.
REQ-006 ivch  input  `VCHW_P1  virtual channel from mux ovch.
REQ-007 iready  output  1  buffer can accept a flit this cycle.
REQ-008 odata  output  `DATAW_P1  flit at FIFO head toward link.
REQ-009 ovalid  output  1  head entry valid.
REQ-010 ovch  output  `VCHW_P1  VC of head flit.
REQ-011 oready  input  1  downstream accepts head flit this cycle.
REQ-012 occ  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 perr  output  1  sticky protocol-error flag (exists only with LINK_OBUF_PCHK_EN).

Function
REQ-014 Push when ivalid && iready; pop when ovalid && oready; both may occur in one cycle.
REQ-015 iready SHALL be combinational !full only; a pop in the same cycle does not raise iready while full.
REQ-016 ovalid = (occ != 0); odata/ovch driven from registered storage at the read pointer, no combinational path from idata.
REQ-017 Latency: flit pushed at edge N is visible on odata/ovalid after edge N (one cycle), never the same cycle.
REQ-018 Pointers wrap modulo DEPTH; occ increments on push-only, decrements on pop-only, unchanged on push+pop.
REQ-019 Flit order preserved strictly FIFO; idata, ivch stored together per entry.
REQ-020 Push while full is impossible (iready=0); pop while empty is ignored, no pointer change.
REQ-021 ivalid with type `TYPE_NONE SHALL be accepted as a push only if iready, stored unchanged (checker flags it, REQ-026).

Reset
REQ-022 On rst: read/write pointers 0, occ 0, ovalid 0, iready 1, odata all zeros, ovch 0, perr 0, checker FSM IDLE.
REQ-023 rst asserted mid-packet or mid-transfer discards all stored flits at the next edge; push/pop in that cycle are ignored.

Configuration
REQ-024 Macro LINK_OBUF_PCHK_EN compiles in the push-side packet checker and perr port; without it perr and checker logic are absent and buffer behaviour is identical.
REQ-025 Checker FSM states IDLE, BODY; evaluated on each accepted push: IDLE+HEAD -> BODY (latch ivch); BODY+DATA -> BODY; BODY+TAIL -> IDLE; other combinations keep state per below.
REQ-026 perr set (sticky until rst) on: DATA/TAIL in IDLE (stay IDLE); HEAD in BODY (stay BODY, relatch ivch); NONE in either state; ivch differing from latched VC in BODY.
REQ-027 Checker never blocks or drops flits.

Structure
REQ-028 `DATAW*, `VCHW*, `TYPE_HEAD/DATA/TAIL/NONE and type-field position come from the shared define file; no local redefinition.
REQ-029 Storage and pointers in sub-module flit_fifo (parameters WIDTH, DEPTH); link_obuf instantiates it plus the optional checker.

Verification
REQ-030 Reset, then push HEAD,DATA x3,TAIL with oready=1 -> each flit on odata one cycle after push, occ never exceeds 1, perr 0.
REQ-031 oready=0, push 5 flits with DEPTH=4 -> iready drops after 4th, occ=4, 5th held upstream; oready=1 -> order HEAD..3rd DATA out, then 5th accepted.
REQ-032 Full buffer, simultaneous ivalid and oready -> pop occurs, no push that cycle, occ=3, next cycle push accepted, occ=4.
REQ-033 Stream 20 packets of 22 flits with random oready (30% low) -> output sequence equals input sequence, pointers wrap many times, no loss/duplication.
REQ-034 With LINK_OBUF_PCHK_EN: DATA flit after reset -> perr=1 next cycle, stays 1 through further legal traffic until rst; vch change mid-packet (0 -> 1) -> perr=1.
REQ-035 rst asserted with occ=3 mid-packet -> next cycle occ=0, ovalid=0, iready=1, perr=0.
